// File: rtl/uart_pkg.sv
// Shared UART constants used by the RX buffer, UARTRx and the TX path.
package uart_pkg;

    localparam int UART_DATA_WIDTH    = 8;
    localparam int UART_RX_FIFO_DEPTH = 16;

    // Pointer width for a power-of-two FIFO: index bits plus one wrap bit.
    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte-stream bundle between the RX buffer (slave) and its consumer (master).
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_RX_FIFO_DEPTH,
    parameter int WIDTH = UART_DATA_WIDTH
);
    localparam int CW = fifo_ptr_w(DEPTH);

    logic [WIDTH-1:0] rx_byte;
    logic             rx_complete;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             overflow_clr;

    modport slave (
        input  rx_byte, rx_complete, rd_en, overflow_clr,
        output rd_data, rd_valid, empty, full, count, overflow
    );

    modport master (
        output rx_byte, rx_complete, rd_en, overflow_clr,
        input  rd_data, rd_valid, empty, full, count, overflow
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and a registered read port.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_RX_FIFO_DEPTH,
    parameter int WIDTH = UART_DATA_WIDTH,
    localparam int PW   = fifo_ptr_w(DEPTH),
    localparam int IW   = PW - 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [PW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;
    logic             rd_accept;
    logic             wr_accept;

    // Flags come straight from the registered pointers.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]) &&
                   (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);
    assign count = wr_ptr_q - rd_ptr_q;

    // A read on an empty FIFO is ignored (no write-through bypass); a write
    // into a full FIFO is allowed only when a read frees a slot this cycle.
    assign rd_accept = rd_en & ~empty;
    assign wr_accept = wr_en & (~full | rd_accept);

    // Next pointer values.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(wr_accept);
        rd_ptr_d = rd_ptr_q + PW'(rd_accept);
    end

    // Storage array; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_q[IW-1:0]] <= wr_data;
        end
    end

    // Pointers and registered read port; rd_data holds the last popped byte.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= rd_accept;
            if (rd_accept) begin
                rd_data_q <= mem[rd_ptr_q[IW-1:0]];
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// RX byte buffer: edge-detects rx_complete, queues bytes, flags drops.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_RX_FIFO_DEPTH,
    parameter int WIDTH = UART_DATA_WIDTH,
    localparam int PW   = fifo_ptr_w(DEPTH)
) (
    input  logic          sourceClk,
    input  logic          reset,
    uart_rx_fifo_if.slave bus
);

    logic             rx_prev_q;
    logic             overflow_q, overflow_d;
    logic             wr;
    logic             drop;
    logic [WIDTH-1:0] fifo_rd_data;
    logic             fifo_rd_valid;
    logic [PW-1:0]    fifo_count;
    logic             fifo_empty;
    logic             fifo_full;

    // One write per rising edge of rx_complete; rx_byte is taken this cycle.
    assign wr = bus.rx_complete & ~rx_prev_q;

    // Byte is lost only when full and no pop frees a slot (full => not empty).
    assign drop = wr & fifo_full & ~bus.rd_en;

    // Sticky overflow; a new drop beats a simultaneous clear.
    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (bus.overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    // rx_prev resets high so a level held through reset is not a new byte.
    always_ff @(posedge sourceClk) begin
        if (reset) begin
            rx_prev_q  <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            rx_prev_q  <= bus.rx_complete;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk      (sourceClk),
        .srst     (reset),
        .wr_en    (wr),
        .wr_data  (bus.rx_byte),
        .rd_en    (bus.rd_en),
        .rd_data  (fifo_rd_data),
        .rd_valid (fifo_rd_valid),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign bus.rd_data  = fifo_rd_data;
    assign bus.rd_valid = fifo_rd_valid;
    assign bus.count    = fifo_count;
    assign bus.empty    = fifo_empty;
    assign bus.full     = fifo_full;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: vector table plus hand-written sequences.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .sourceClk (clk),
        .reset     (reset),
        .bus       (bus)
    );

    typedef struct {
        logic       rxc;
        logic [7:0] din;
        logic       rd;
        logic       clr;
        logic       rv;
        logic [7:0] rdat;
        int         cnt;
        logic       emp;
        logic       ful;
        logic       ovf;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic rv, input logic [7:0] rdat,
                           input int cnt, input logic emp, input logic ful, input logic ovf);
        chk({nm, ".rd_valid"}, 32'(bus.rd_valid), 32'(rv));
        chk({nm, ".rd_data"},  32'(bus.rd_data),  32'(rdat));
        chk({nm, ".count"},    32'(bus.count),    32'(cnt));
        chk({nm, ".empty"},    32'(bus.empty),    32'(emp));
        chk({nm, ".full"},     32'(bus.full),     32'(ful));
        chk({nm, ".overflow"}, 32'(bus.overflow), 32'(ovf));
    endtask

    // Inputs change 1 ns after a rising edge; outputs are sampled then too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        bus.rx_complete = 1'b1;
        bus.rx_byte     = b;
        step();
        bus.rx_complete = 1'b0;
        step();
    endtask

    logic [7:0] last;
    logic [7:0] expd;

    initial begin
        // rxc din rd clr | rv rdat cnt emp ful ovf
        vecs[0]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'h41, 1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h41, 0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h41, 0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h41, 0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h41, 0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h41, 0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 8'h41, 1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h55, 0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 8'h55, 1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 8'h77, 1'b0, 1'b0, 1'b0, 8'h55, 1, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 8'h55, 2, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h66, 1, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 8'h88, 1'b1, 1'b0, 1'b1, 8'h77, 1, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h88, 0, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h88, 0, 1'b1, 1'b0, 1'b0};

        reset            = 1'b1;
        bus.rx_complete  = 1'b0;
        bus.rx_byte      = '0;
        bus.rd_en        = 1'b0;
        bus.overflow_clr = 1'b0;
        step();
        step();
        chk_out("reset", 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        step();

        // Table: single write, empty reads, write+read while empty/non-empty.
        for (int i = 0; i < NVEC; i++) begin
            bus.rx_complete  = vecs[i].rxc;
            bus.rx_byte      = vecs[i].din;
            bus.rd_en        = vecs[i].rd;
            bus.overflow_clr = vecs[i].clr;
            step();
            $display("vec %0d: rx_complete=%0b rx_byte=%02h rd_en=%0b -> rd_valid=%0b rd_data=%02h count=%0d",
                     i, vecs[i].rxc, vecs[i].din, vecs[i].rd, bus.rd_valid, bus.rd_data, bus.count);
            chk_out($sformatf("vec%0d", i), vecs[i].rv, vecs[i].rdat, vecs[i].cnt,
                    vecs[i].emp, vecs[i].ful, vecs[i].ovf);
        end
        bus.rd_en = 1'b0;

        // Fill with 0x00..0x0F.
        for (int i = 0; i < DEPTH; i++) begin
            push(8'(i));
            chk($sformatf("fill%0d.count", i), 32'(bus.count), 32'(i + 1));
        end
        $display("fill: count=%0d full=%0b", bus.count, bus.full);
        chk_out("filled", 1'b0, 8'h88, 16, 1'b0, 1'b1, 1'b0);

        // 17th byte is dropped.
        bus.rx_complete = 1'b1;
        bus.rx_byte     = 8'hAA;
        step();
        $display("drop AA: count=%0d overflow=%0b", bus.count, bus.overflow);
        chk_out("drop", 1'b0, 8'h88, 16, 1'b0, 1'b1, 1'b1);
        bus.rx_complete = 1'b0;
        step();

        // Drop and clear together: set wins.
        bus.rx_complete  = 1'b1;
        bus.rx_byte      = 8'hBB;
        bus.overflow_clr = 1'b1;
        step();
        $display("drop BB with clear: overflow=%0b", bus.overflow);
        chk_out("drop_clr", 1'b0, 8'h88, 16, 1'b0, 1'b1, 1'b1);
        bus.rx_complete = 1'b0;
        step();
        $display("clear alone: overflow=%0b", bus.overflow);
        chk_out("clr", 1'b0, 8'h88, 16, 1'b0, 1'b1, 1'b0);
        bus.overflow_clr = 1'b0;

        // Write and read together while full: no overflow, 0x99 goes last.
        bus.rx_complete = 1'b1;
        bus.rx_byte     = 8'h99;
        bus.rd_en       = 1'b1;
        step();
        $display("full wr+rd: rd_data=%02h count=%0d", bus.rd_data, bus.count);
        chk_out("full_wr_rd", 1'b1, 8'h00, 16, 1'b0, 1'b1, 1'b0);
        bus.rx_complete = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            step();
            expd = (k < DEPTH) ? 8'(k) : 8'h99;
            $display("drain %0d: rd_valid=%0b rd_data=%02h count=%0d", k, bus.rd_valid, bus.rd_data, bus.count);
            chk_out($sformatf("drain%0d", k), 1'b1, expd, DEPTH - k, (k == DEPTH), 1'b0, 1'b0);
        end
        bus.rd_en = 1'b0;
        step();
        chk_out("drained", 1'b0, 8'h99, 0, 1'b1, 1'b0, 1'b0);

        // Reset with 5 bytes stored and rx_complete held high across it.
        for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
        chk("pre_reset.count", 32'(bus.count), 32'd5);
        bus.rx_complete = 1'b1;
        bus.rx_byte     = 8'hEE;
        reset           = 1'b1;
        step();
        $display("mid reset: count=%0d empty=%0b", bus.count, bus.empty);
        chk_out("mid_reset", 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("held_rxc%0d", i), 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0);
        end
        bus.rx_complete = 1'b0;
        step();

        // Wrap-around: 40 write/read pairs, pointers pass the wrap bit.
        last = 8'h00;
        for (int i = 0; i < 40; i++) begin
            bus.rx_complete = 1'b1;
            bus.rx_byte     = 8'(i);
            bus.rd_en       = 1'b0;
            step();
            chk_out($sformatf("wrap_wr%0d", i), 1'b0, last, 1, 1'b0, 1'b0, 1'b0);
            bus.rx_complete = 1'b0;
            bus.rd_en       = 1'b1;
            step();
            $display("wrap %0d: rd_valid=%0b rd_data=%02h", i, bus.rd_valid, bus.rd_data);
            chk_out($sformatf("wrap_rd%0d", i), 1'b1, 8'(i), 0, 1'b1, 1'b0, 1'b0);
            last = 8'(i);
        end
        bus.rd_en = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
